clk_div_gen: RTL and testbench
==============================

# clk_div_gen

Parametrised multi-channel clock-enable/divided-clock generator replacing the fixed free-running divider in the FPGA top level. Each channel has a runtime-programmable divisor and output mode, a per-channel run gate, and a global phase-sync. It produces a one-cycle `tick` strobe for clock-enabling downstream logic such as the CPU core, plus a registered `clk_out` per channel. A compile-time single-step feature is available for board-level debug.

## Interface

Parameters:
- `WIDTH`, 22: divisor and counter width in bits.
- `CH_BITS`, 1: channel-select width; `CHANNELS = 2**CH_BITS`.
- `DEF_DIV`, 22'h3FFFFF: reset divisor for every channel; width `WIDTH`.
- `DEF_MODE`, 1: reset mode for every channel; 0 = strobe, 1 = square.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `cfg_we`  in  1  config write strobe, one cycle.
- `cfg_ch`  in  CH_BITS  channel addressed by the write.
- `cfg_div`  in  WIDTH  divisor D; tick period is D+1 cycles.
- `cfg_mode`  in  1  output mode written with the divisor.
- `run`  in  CHANNELS  per-channel count enable, level.
- `sync`  in  1  restart all channels in phase, one cycle.
- `step`  in  1  single-step request; functional only with `CLKDIV_STEP_EN`.
- `tick`  out  CHANNELS  registered one-cycle terminal-count strobe.
- `clk_out`  out  CHANNELS  registered divided clock.

## Operation

- Per-channel state: `div[WIDTH]`, `mode`, `cnt[WIDTH]`, `tick`, `clk_out`.
- Reset (async): `div=DEF_DIV`, `mode=DEF_MODE`, `cnt=0`, `tick=0`, `clk_out=0` on all channels.
- Per-edge priority per channel: cfg write to this channel, then sync, then advance, then hold.
- Cfg write to channel c loads `div`/`mode` from `cfg_div`/`cfg_mode` and clears `cnt`, `tick` and `clk_out`. Other channels are unaffected.
- Sync clears `cnt`, `tick` and `clk_out` on all channels; `div` and `mode` are kept.
- Cfg write and sync in the same cycle: the written channel loads its new config, and every channel clears.
- Advance occurs when `run[i]=1`, or with `step=1` when stepping applies (see Configuration).
- Advance when `cnt==div`:
  - `cnt<=0`, `tick<=1`.
  - Mode 1: `clk_out` toggles.
  - Mode 0: `clk_out<=1`.
- Advance otherwise: `cnt<=cnt+1`, `tick<=0`, and `clk_out<=0` in mode 0 (held in mode 1).
- Hold (no advance): `cnt` and `clk_out` are kept, `tick<=0`.
- Compare is equality, so `cnt` never exceeds `div` and no counter wrap occurs. D=0 gives `tick` high every cycle and, in mode 1, `clk_out` = clk/2.

## Timing

- Outputs are registered, with no combinational path from inputs to outputs.
- With `run` high from the first edge after reset release, the first `tick` is visible after edge D+1. After that, `tick` is high for 1 cycle every D+1 cycles.
- Mode 1 `clk_out` period is 2·(D+1) cycles with 50% duty; its first rising edge coincides with the first `tick`.
- Mode 0 `clk_out` equals `tick`.
- A new divisor takes effect immediately: for a write at edge E, the first tick follows edge E+D+1.
- Lowering `run` mid-period freezes `cnt`. Reasserting `run` resumes from the frozen value, with no restart.
- Reset asserted mid-period clears state asynchronously. Counting restarts from 0 on the first edge after release.

## Configuration

- Macro: `CLKDIV_STEP_EN`.
- Defined:
  - Each cycle with `step=1` advances, by exactly one count, every channel whose `run[i]=0`.
  - Running channels ignore `step`.
  - Holding `step` high for N cycles gives N advances.
- Undefined: `step` is ignored, no step logic is synthesised, and the port remains present.

## Test plan

- Reset defaults with WIDTH=4, DEF_DIV=3, DEF_MODE=1, `run=2'b11` -> `tick` pulses every 4 cycles, and `clk_out` has an 8-cycle period, first rising with the first tick at edge 4.
- Write ch1 D=0 mode 0 mid-period -> ch1 `tick`/`clk_out` high every cycle starting at edge E+1; ch0 phase is unchanged.
- `run[0]` dropped at `cnt=2` for 5 cycles with D=3 -> no ticks while low; a tick occurs 2 edges after reassertion.
- Channels with D=3 and D=5 at differing phases, `sync` pulsed -> both clear, and ticks then land at sync+4 and sync+6.
- `sync` together with a write to ch0 (D=1) -> all `cnt` clear, and ch0 ticks every 2 cycles from then on.
- With `CLKDIV_STEP_EN`, `run=0`, D=2: three single-cycle `step` pulses -> exactly one `tick` after the 3rd; without the macro, no tick.

Source files
------------

// File: rtl/clk_div_gen.sv
// clk_div_gen: multi-channel clock-enable / divided-clock generator.
//
// Each channel counts 0..D and raises a one-cycle registered `tick` when the
// count equals D, giving a tick period of D+1 cycles. `clk_out` is either a
// copy of the tick (mode 0, strobe) or a toggle-on-tick square wave (mode 1).
//
// Configuration interface: `cfg_we` is a fire-and-forget one-cycle strobe.
// There is no ready/acknowledge; the write is accepted on the edge where
// cfg_we is high and lands in channel `cfg_ch` only.
//
// Optional feature macro: CLKDIV_STEP_EN. When defined, each cycle with
// `step` high advances every non-running channel by one count. When
// undefined, `step` is accepted but has no effect.
module clk_div_gen #(
  parameter int               WIDTH    = 22,
  parameter int               CH_BITS  = 1,
  parameter logic [WIDTH-1:0] DEF_DIV  = {WIDTH{1'b1}},
  parameter logic             DEF_MODE = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cfg_we,
  input  logic [CH_BITS-1:0]      cfg_ch,
  input  logic [WIDTH-1:0]        cfg_div,
  input  logic                    cfg_mode,
  input  logic [2**CH_BITS-1:0]   run,
  input  logic                    sync,
  input  logic                    step,
  output logic [2**CH_BITS-1:0]   tick,
  output logic [2**CH_BITS-1:0]   clk_out
);

  localparam int CHANNELS = 2**CH_BITS;

  // Per-channel advance qualifier: the run level, optionally widened by step.
  logic [CHANNELS-1:0] adv;

`ifdef CLKDIV_STEP_EN
  // A step pulse only moves channels that are parked; running ones count anyway.
  assign adv = run | ({CHANNELS{step}} & ~run);
`else
  logic unused_step;
  assign unused_step = step;
  assign adv         = run;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] div_r;
    logic             mode_r;
    logic [WIDTH-1:0] cnt_r;
    logic             tick_r;
    logic             cout_r;
    logic             wr_hit;
    logic             at_term;

    assign wr_hit  = cfg_we && (cfg_ch == CH_BITS'(i));
    assign at_term = (cnt_r == div_r);

    // Channel state: config write beats sync, sync beats advance, else hold.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        div_r  <= DEF_DIV;
        mode_r <= DEF_MODE;
        cnt_r  <= '0;
        tick_r <= 1'b0;
        cout_r <= 1'b0;
      end else if (wr_hit) begin
        div_r  <= cfg_div;
        mode_r <= cfg_mode;
        cnt_r  <= '0;
        tick_r <= 1'b0;
        cout_r <= 1'b0;
      end else if (sync) begin
        cnt_r  <= '0;
        tick_r <= 1'b0;
        cout_r <= 1'b0;
      end else if (adv[i]) begin
        if (at_term) begin
          // Equality compare keeps cnt within 0..div, so no wrap handling.
          cnt_r  <= '0;
          tick_r <= 1'b1;
          cout_r <= mode_r ? ~cout_r : 1'b1;
        end else begin
          cnt_r  <= cnt_r + 1'b1;
          tick_r <= 1'b0;
          if (!mode_r) cout_r <= 1'b0;
        end
      end else begin
        tick_r <= 1'b0;
      end
    end

    assign tick[i]    = tick_r;
    assign clk_out[i] = cout_r;
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// tb_clk_div_gen: directed bench for clk_div_gen (WIDTH=4, 2 channels,
// DEF_DIV=3, DEF_MODE=1). A behavioural model counts advances since the last
// clear and derives tick/clk_out arithmetically; a compare process checks the
// DUT against it every cycle, and literal checks pin known edges.
module tb_clk_div_gen;

  localparam int WIDTH   = 4;
  localparam int CH_BITS = 1;
  localparam int CHN     = 2;

  logic             clk;
  logic             reset;
  logic             cfg_we;
  logic [CH_BITS-1:0] cfg_ch;
  logic [WIDTH-1:0] cfg_div;
  logic             cfg_mode;
  logic [CHN-1:0]   run;
  logic             sync;
  logic             step;
  logic [CHN-1:0]   tick;
  logic [CHN-1:0]   clk_out;

  int n_checks = 0;
  int n_fail   = 0;

  clk_div_gen #(
    .WIDTH   (WIDTH),
    .CH_BITS (CH_BITS),
    .DEF_DIV (4'd3),
    .DEF_MODE(1'b1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .cfg_we  (cfg_we),
    .cfg_ch  (cfg_ch),
    .cfg_div (cfg_div),
    .cfg_mode(cfg_mode),
    .run     (run),
    .sync    (sync),
    .step    (step),
    .tick    (tick),
    .clk_out (clk_out)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef CLKDIV_STEP_EN
  localparam bit STEP_ON = 1'b1;
`else
  localparam bit STEP_ON = 1'b0;
`endif

  // Behavioural model: n = advances since last clear; a tick lands whenever n
  // is a nonzero multiple of D+1; square output is the parity of ticks so far.
  int m_div  [CHN];
  int m_mode [CHN];
  int m_n    [CHN];
  bit m_tick [CHN];
  bit m_cout [CHN];

  always @(posedge clk or posedge reset) begin
    for (int c = 0; c < CHN; c++) begin
      if (reset) begin
        m_div[c] = 3; m_mode[c] = 1; m_n[c] = 0; m_tick[c] = 0; m_cout[c] = 0;
      end else if (cfg_we && int'(cfg_ch) == c) begin
        m_div[c] = int'(cfg_div); m_mode[c] = int'(cfg_mode);
        m_n[c] = 0; m_tick[c] = 0; m_cout[c] = 0;
      end else if (sync) begin
        m_n[c] = 0; m_tick[c] = 0; m_cout[c] = 0;
      end else if (run[c] || (STEP_ON && step)) begin
        m_n[c]    = m_n[c] + 1;
        m_tick[c] = (m_n[c] % (m_div[c] + 1)) == 0;
        m_cout[c] = (m_mode[c] != 0) ? (((m_n[c] / (m_div[c] + 1)) % 2) == 1)
                                      : m_tick[c];
      end else begin
        m_tick[c] = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Scoreboard compare against the model on every falling edge.
  always @(negedge clk) begin
    for (int c = 0; c < CHN; c++) begin
      check($sformatf("model_tick[%0d]", c), 32'(tick[c]), 32'(m_tick[c]));
      check($sformatf("model_clk_out[%0d]", c), 32'(clk_out[c]), 32'(m_cout[c]));
    end
  end

  // Driver tasks (inputs change on falling edges only)
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg_write(input int ch, input int dv, input bit md, input bit with_sync);
    cfg_we = 1'b1; cfg_ch = CH_BITS'(ch); cfg_div = WIDTH'(dv); cfg_mode = md;
    sync = with_sync;
    cyc(1);
    cfg_we = 1'b0; sync = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_mode = 1'b0;
    run = '0; sync = 1'b0; step = 1'b0;
    cyc(2);
    check("reset_tick", 32'(tick), 32'h0);
    check("reset_clk_out", 32'(clk_out), 32'h0);

    // Reset defaults, both channels running: release at edge-0 reference.
    run = 2'b11; reset = 1'b0;
    cyc(3);  check("def_tick_e3", 32'(tick), 32'h0);
    cyc(1);  check("def_tick_e4", 32'(tick), 32'h3);
             check("def_clk_e4", 32'(clk_out), 32'h3);
    cyc(1);  check("def_tick_e5", 32'(tick), 32'h0);
             check("def_clk_e5", 32'(clk_out), 32'h3);
    cyc(3);  check("def_tick_e8", 32'(tick), 32'h3);
             check("def_clk_e8", 32'(clk_out), 32'h0);
    cyc(1);

    // Write ch1 D=0 mode 0 at edge 10; ch0 keeps its phase.
    cfg_write(1, 0, 1'b0, 1'b0);
    check("wr_tick_e10", 32'(tick), 32'h0);
    cyc(1);  check("wr_tick_e11", 32'(tick), 32'h2);
             check("wr_clk_e11", 32'(clk_out), 32'h2);
    cyc(1);  check("wr_tick_e12", 32'(tick), 32'h3);
             check("wr_clk_e12", 32'(clk_out), 32'h3);

    // Drop run[0] at cnt=2 for 5 cycles; tick two edges after reassertion.
    cyc(2);  run = 2'b10;
    cyc(5);  check("hold_tick_e19", 32'(tick[0]), 32'h0);
    run = 2'b11;
    cyc(1);  check("resume_tick_e20", 32'(tick[0]), 32'h0);
    cyc(1);  check("resume_tick_e21", 32'(tick[0]), 32'h1);

    // ch1 -> D=5 mode 1, let phases differ, then sync at edge 25.
    cfg_write(1, 5, 1'b1, 1'b0);
    cyc(2);
    sync = 1'b1;
    cyc(1);  sync = 1'b0;
    cyc(3);  check("sync_tick_e28", 32'(tick), 32'h0);
    cyc(1);  check("sync_tick_e29", 32'(tick), 32'h1);
    cyc(2);  check("sync_tick_e31", 32'(tick), 32'h2);

    // Sync together with a write of ch0 D=1 at edge 32.
    cfg_write(0, 1, 1'b1, 1'b1);
    check("ws_tick_e32", 32'(tick), 32'h0);
    cyc(1);  check("ws_tick_e33", 32'(tick), 32'h0);
    cyc(1);  check("ws_tick_e34", 32'(tick), 32'h1);
    cyc(1);  check("ws_tick_e35", 32'(tick), 32'h0);
    cyc(1);  check("ws_tick_e36", 32'(tick), 32'h1);
    cyc(2);  check("ws_tick_e38", 32'(tick), 32'h3);

    // Single step: run=0, ch0 D=2 mode 0, three one-cycle step pulses.
    run = 2'b00;
    cfg_write(0, 2, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step = 1'b1; cyc(1);
      step = 1'b0;
      if (k < 2) begin
        check("step_no_tick", 32'(tick[0]), 32'h0);
        cyc(1);
      end
    end
    check("step_tick_3rd", 32'(tick[0]), 32'(STEP_ON));
    cyc(1);  check("step_after", 32'(tick[0]), 32'h0);

    // Asynchronous reset mid-period, then restart from defaults.
    run = 2'b11;
    cyc(6);
    #2 reset = 1'b1;
    #1 check("async_rst_tick", 32'(tick), 32'h0);
       check("async_rst_clk", 32'(clk_out), 32'h0);
    cyc(1);  reset = 1'b0;
    cyc(3);  check("rst2_tick_e3", 32'(tick), 32'h0);
    cyc(1);  check("rst2_tick_e4", 32'(tick), 32'h3);
             check("rst2_clk_e4", 32'(clk_out), 32'h3);
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
